// File: rtl/decode_sb.sv
// RV32 decode / register-read stage with a busy-bit scoreboard and writeback bypass.
// Accepts one instruction per cycle and presents a registered operand bundle to execute.

package decode_sb_pkg;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB    = 5'd1,  ALU_SLT    = 5'd2,  ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,  ALU_OR     = 5'd5,  ALU_AND    = 5'd6,  ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,  ALU_SRA    = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12, ALU_MULHU  = 5'd13, ALU_DIV    = 5'd14, ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16, ALU_REMU   = 5'd17, ALU_LUI    = 5'd18, ALU_AUIPC  = 5'd19,
    ALU_JAL    = 5'd20, ALU_SEQ    = 5'd21, ALU_SNE    = 5'd22, ALU_SGE    = 5'd23,
    ALU_SGEU   = 5'd24, ALU_SADDR  = 5'd25
  } alu_op_e;
endpackage

module decode_sb
  import decode_sb_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int BYPASS     = 1,
  parameter int SCOREBOARD = 1,
  parameter int ENABLE_M   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] instr_addr,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] q_instr,
  output logic [31:0] q_instr_addr,
  output logic [31:0] q_r1,
  output logic [31:0] q_r2,
  output logic [31:0] q_r2s,
  output logic [4:0]  q_alu_op,
  output logic [31:0] q_jmp_addr,
  output logic        q_illegal,
  output logic        q_valid,
  input  logic        q_ready,
  input  logic [4:0]  write_reg_number,
  input  logic [31:0] write_reg_value,
  input  logic        write_reg,
  input  logic        jmp,
  input  logic        stall,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  localparam logic [5:0] NREGS_L = 6'(NREGS);
  localparam bit BYP = (BYPASS != 0);
  localparam bit SB  = (SCOREBOARD != 0);
  localparam bit HAS_M = (ENABLE_M != 0);

  typedef enum logic [6:0] {
    OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111,
    OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP   = 7'b0110011
  } opcode_e;

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  logic [31:0] regs [32];
  logic [31:0] busy, busy_next;
  logic [4:0]  q_rd;
  logic        q_set_busy;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  logic        uses_rs1, uses_rs2, writes_rd, bad_enc, illegal;
  alu_op_e     alu_raw, alu_sel;

  // Instruction classification: operand usage, ALU op and encoding validity.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    bad_enc   = 1'b0;
    alu_raw   = ALU_ADD;
    case (opcode)
      OPC_LUI:   begin writes_rd = 1'b1; alu_raw = ALU_LUI; end
      OPC_AUIPC: begin writes_rd = 1'b1; alu_raw = ALU_AUIPC; end
      OPC_JAL:   begin writes_rd = 1'b1; alu_raw = ALU_JAL; end
      OPC_JALR:  begin uses_rs1 = 1'b1; writes_rd = 1'b1; alu_raw = ALU_JAL; end
      OPC_LOAD:  begin uses_rs1 = 1'b1; writes_rd = 1'b1; alu_raw = ALU_ADD; end
      OPC_STORE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_raw = ALU_SADDR; end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        case (f3)
          3'b000:  alu_raw = ALU_SEQ;
          3'b001:  alu_raw = ALU_SNE;
          3'b100:  alu_raw = ALU_SLT;
          3'b101:  alu_raw = ALU_SGE;
          3'b110:  alu_raw = ALU_SLTU;
          3'b111:  alu_raw = ALU_SGEU;
          default: bad_enc = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        case (f3)
          3'b000:  alu_raw = ALU_ADD;
          3'b001:  alu_raw = ALU_SLL;
          3'b010:  alu_raw = ALU_SLT;
          3'b011:  alu_raw = ALU_SLTU;
          3'b100:  alu_raw = ALU_XOR;
          3'b101:  alu_raw = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_raw = ALU_OR;
          default: alu_raw = ALU_AND;
        endcase
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        if (f7 == 7'b0000001) begin
          bad_enc = !HAS_M;
          case (f3)
            3'b000:  alu_raw = ALU_MUL;
            3'b001:  alu_raw = ALU_MULH;
            3'b010:  alu_raw = ALU_MULHSU;
            3'b011:  alu_raw = ALU_MULHU;
            3'b100:  alu_raw = ALU_DIV;
            3'b101:  alu_raw = ALU_DIVU;
            3'b110:  alu_raw = ALU_REM;
            default: alu_raw = ALU_REMU;
          endcase
        end else if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          case (f3)
            3'b000:  alu_raw = instr[30] ? ALU_SUB : ALU_ADD;
            3'b001:  alu_raw = ALU_SLL;
            3'b010:  alu_raw = ALU_SLT;
            3'b011:  alu_raw = ALU_SLTU;
            3'b100:  alu_raw = ALU_XOR;
            3'b101:  alu_raw = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_raw = ALU_OR;
            default: alu_raw = ALU_AND;
          endcase
        end else begin
          bad_enc = 1'b1;
        end
      end
      default: begin uses_rs1 = 1'b1; bad_enc = 1'b1; end
    endcase
    writes_rd = writes_rd && (rd != 5'd0);
  end

  assign illegal = bad_enc || (uses_rs1 && !in_range(rs1)) || (uses_rs2 && !in_range(rs2))
                   || (writes_rd && !in_range(rd));
  assign alu_sel = illegal ? ALU_ADD : alu_raw;

  // Operand read with optional same-cycle writeback forwarding.
  logic [31:0] r1_rf, r2_rf, op1, op2;
  logic        fwd1, fwd2, fwd_rd, hazard, accept;
  assign r1_rf  = (rs1 != 5'd0 && in_range(rs1)) ? regs[rs1] : 32'd0;
  assign r2_rf  = (rs2 != 5'd0 && in_range(rs2)) ? regs[rs2] : 32'd0;
  assign fwd1   = BYP && write_reg && write_reg_number == rs1 && rs1 != 5'd0;
  assign fwd2   = BYP && write_reg && write_reg_number == rs2 && rs2 != 5'd0;
  assign fwd_rd = BYP && write_reg && write_reg_number == rd  && rd  != 5'd0;
  assign op1    = fwd1 ? write_reg_value : r1_rf;
  assign op2    = fwd2 ? write_reg_value : r2_rf;

  assign hazard = SB && valid && ((uses_rs1 && busy[rs1] && !fwd1) || (uses_rs2 && busy[rs2] && !fwd2)
                                  || (writes_rd && busy[rd] && !fwd_rd));
  assign ready  = (!q_valid || q_ready) && !stall && !jmp && !hazard;
  assign accept = valid && ready;

  assign dbg_data = (dbg_sel != 5'd0 && in_range(dbg_sel)) ? regs[dbg_sel] : 32'd0;

  // Register file: writeback every cycle, zeroed on reset.
  always_ff @(posedge clk) begin
    // NOTE: the regfile is reset because mid-stream reset must zero architectural state; this costs a flop reset per bit.
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (write_reg && write_reg_number != 5'd0 && in_range(write_reg_number)) begin
      regs[write_reg_number] <= write_reg_value;
    end
  end

  // Scoreboard next state: writeback and flush clears first, then a new issue sets (set wins).
  always_comb begin
    busy_next = busy;
    if (write_reg) busy_next[write_reg_number] = 1'b0;
    if (jmp && q_valid && q_set_busy) busy_next[q_rd] = 1'b0;
    if (accept && writes_rd && !illegal) busy_next[rd] = 1'b1;
    if (!SB) busy_next = 32'd0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) busy <= 32'd0;
    else        busy <= busy_next;
  end

  // Output bundle: captured on accept, held under back-pressure, dropped on flush or consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_instr      <= 32'd0;
      q_instr_addr <= 32'd0;
      q_r1         <= 32'd0;
      q_r2         <= 32'd0;
      q_r2s        <= 32'd0;
      q_alu_op     <= ALU_ADD;
      q_jmp_addr   <= 32'd0;
      q_illegal    <= 1'b0;
      q_valid      <= 1'b0;
      q_rd         <= 5'd0;
      q_set_busy   <= 1'b0;
    end else if (accept) begin
      q_instr      <= instr;
      q_instr_addr <= instr_addr;
      q_r1         <= op1;
      q_r2         <= instr[5] ? op2 : {{20{instr[31]}}, instr[31:20]};
      q_r2s        <= op2;
      q_alu_op     <= alu_sel;
      q_jmp_addr   <= instr_addr + {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      q_illegal    <= illegal;
      q_valid      <= 1'b1;
      q_rd         <= rd;
      q_set_busy   <= writes_rd && !illegal;
    end else if (jmp || q_ready) begin
      q_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_sb.sv
// Directed bench for decode_sb: default build plus an RV32E / no-M / no-bypass build.
module tb_decode_sb;
  import decode_sb_pkg::*;

  logic        clk, rst_n;
  logic [31:0] instr, instr_addr;
  logic        valid, valid_e, q_ready;
  logic [4:0]  write_reg_number, dbg_sel;
  logic [31:0] write_reg_value;
  logic        write_reg, jmp, stall;

  logic        ready, q_illegal, q_valid;
  logic [31:0] q_instr, q_instr_addr, q_r1, q_r2, q_r2s, q_jmp_addr, dbg_data;
  logic [4:0]  q_alu_op;

  logic        ready_e, q_illegal_e, q_valid_e;
  logic [31:0] q_instr_e, q_instr_addr_e, q_r1_e, q_r2_e, q_r2s_e, q_jmp_addr_e, dbg_data_e;
  logic [4:0]  q_alu_op_e;

  int n_cmp = 0;
  int n_err = 0;

  decode_sb dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_addr(instr_addr), .valid(valid), .ready(ready),
    .q_instr(q_instr), .q_instr_addr(q_instr_addr), .q_r1(q_r1), .q_r2(q_r2), .q_r2s(q_r2s),
    .q_alu_op(q_alu_op), .q_jmp_addr(q_jmp_addr), .q_illegal(q_illegal), .q_valid(q_valid),
    .q_ready(q_ready), .write_reg_number(write_reg_number), .write_reg_value(write_reg_value),
    .write_reg(write_reg), .jmp(jmp), .stall(stall), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  decode_sb #(.NREGS(16), .BYPASS(0), .SCOREBOARD(1), .ENABLE_M(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_addr(instr_addr), .valid(valid_e), .ready(ready_e),
    .q_instr(q_instr_e), .q_instr_addr(q_instr_addr_e), .q_r1(q_r1_e), .q_r2(q_r2_e), .q_r2s(q_r2s_e),
    .q_alu_op(q_alu_op_e), .q_jmp_addr(q_jmp_addr_e), .q_illegal(q_illegal_e), .q_valid(q_valid_e),
    .q_ready(q_ready), .write_reg_number(write_reg_number), .write_reg_value(write_reg_value),
    .write_reg(write_reg), .jmp(jmp), .stall(stall), .dbg_sel(dbg_sel), .dbg_data(dbg_data_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] n, input logic [31:0] v);
    write_reg = 1'b1; write_reg_number = n; write_reg_value = v;
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_addr = '0; valid = 1'b0; valid_e = 1'b0; q_ready = 1'b1;
    write_reg = 1'b0; write_reg_number = '0; write_reg_value = '0; jmp = 1'b0; stall = 1'b0; dbg_sel = '0;
    tick(); tick();
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_alu_op", 32'(q_alu_op), 32'(ALU_ADD));
    check("rst_q_instr", q_instr, 32'd0);
    check("rst_busy", dut.busy, 32'd0);
    check("rst_illegal", 32'(q_illegal), 32'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    instr = 32'h00500093; instr_addr = 32'h100; valid = 1'b1;
    #1 check("addi_ready", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    check("addi_q_valid", 32'(q_valid), 32'd1);
    check("addi_q_r1", q_r1, 32'd0);
    check("addi_q_r2", q_r2, 32'd5);
    check("addi_alu", 32'(q_alu_op), 32'(ALU_ADD));
    check("addi_busy", dut.busy, 32'h2);
    wb(5'd1, 32'd5);
    tick();
    write_reg = 1'b0; dbg_sel = 5'd1;
    #1 check("x1_dbg", dbg_data, 32'd5);
    check("x1_busy_clr", dut.busy, 32'd0);

    // lw x2,0(x1) then add x3,x2,x2 (load-use with bypass)
    instr = 32'h0000A103; valid = 1'b1;
    tick();
    check("lw_q_r1", q_r1, 32'd5);
    check("lw_busy", dut.busy, 32'h4);
    instr = 32'h002101B3;
    #1 check("ld_use_stall0", 32'(ready), 32'd0);
    tick();
    check("ld_use_stall1", 32'(ready), 32'd0);
    wb(5'd2, 32'h1234);
    #1 check("ld_use_fwd_ready", 32'(ready), 32'd1);
    tick();
    write_reg = 1'b0;
    check("add_q_instr", q_instr, 32'h002101B3);
    check("add_q_r1", q_r1, 32'h1234);
    check("add_q_r2s", q_r2s, 32'h1234);
    check("add_q_r2", q_r2, 32'h1234);
    check("add_busy", dut.busy, 32'h8);

    // Back-pressure: lui x5 waits while add is held
    q_ready = 1'b0; instr = 32'hABCDE2B7;
    #1 check("bp_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_instr", q_instr, 32'h002101B3);
      check("bp_hold_valid", 32'(q_valid), 32'd1);
    end
    q_ready = 1'b1;
    #1 check("bp_release_ready", 32'(ready), 32'd1);
    tick();
    valid = 1'b0; q_ready = 1'b0;
    check("lui_q_instr", q_instr, 32'hABCDE2B7);
    check("lui_alu", 32'(q_alu_op), 32'(ALU_LUI));
    check("lui_busy", dut.busy, 32'h28);
    tick();
    check("lui_held", 32'(q_valid), 32'd1);

    // Flush the held lui
    jmp = 1'b1;
    #1 check("jmp_ready", 32'(ready), 32'd0);
    tick();
    jmp = 1'b0;
    check("jmp_q_valid", 32'(q_valid), 32'd0);
    check("jmp_busy5_clr", dut.busy, 32'h8);
    wb(5'd0, 32'hDEAD);
    tick();
    dbg_sel = 5'd0;
    #1 check("x0_reads_0", dbg_data, 32'd0);
    wb(5'd3, 32'd7);
    tick();
    write_reg = 1'b0; dbg_sel = 5'd3;
    #1 check("x3_dbg", dbg_data, 32'd7);
    check("x3_busy_clr", dut.busy, 32'd0);

    // mul x1,x2,x3 with M enabled
    q_ready = 1'b1; valid = 1'b1; instr = 32'h023100B3;
    tick();
    valid = 1'b0;
    check("mul_alu", 32'(q_alu_op), 32'(ALU_MUL));
    check("mul_illegal", 32'(q_illegal), 32'd0);
    check("mul_r1", q_r1, 32'h1234);
    check("mul_r2", q_r2, 32'd7);
    check("mul_busy", dut.busy, 32'h2);
    wb(5'd1, 32'd5);
    tick();
    write_reg = 1'b0;

    // Branches: funct3 010 is illegal, 101 is BGE
    valid = 1'b1; instr = 32'h0020A063;
    tick();
    check("br010_illegal", 32'(q_illegal), 32'd1);
    check("br010_alu", 32'(q_alu_op), 32'(ALU_ADD));
    check("br010_busy", dut.busy, 32'd0);
    instr = 32'h0020D063;
    tick();
    check("bge_illegal", 32'(q_illegal), 32'd0);
    check("bge_alu", 32'(q_alu_op), 32'(ALU_SGE));
    check("bge_r1", q_r1, 32'd5);
    check("bge_r2s", q_r2s, 32'h1234);

    // addi x4,x1,-1 ; jal x1,-4 ; jal x0,+8 at 0x200
    instr_addr = 32'h200; instr = 32'hFFF08213;
    tick();
    check("addi_neg_r1", q_r1, 32'd5);
    check("addi_neg_r2", q_r2, 32'hFFFFFFFF);
    check("addi_neg_busy", dut.busy, 32'h10);
    instr = 32'hFFDFF0EF;
    tick();
    check("jal_neg_target", q_jmp_addr, 32'h1FC);
    check("jal_neg_alu", 32'(q_alu_op), 32'(ALU_JAL));
    check("jal_neg_busy", dut.busy, 32'h12);
    instr = 32'h0080006F;
    tick();
    valid = 1'b0;
    check("jal_pos_target", q_jmp_addr, 32'h208);
    check("jal_x0_busy", dut.busy, 32'h12);

    // RV32E / no-M / no-bypass build
    valid_e = 1'b1; instr = 32'h00208A33;
    tick();
    check("e_x20_illegal", 32'(q_illegal_e), 32'd1);
    check("e_x20_alu", 32'(q_alu_op_e), 32'(ALU_ADD));
    check("e_x20_busy", dut_e.busy, 32'd0);
    instr = 32'h023100B3;
    tick();
    check("e_mul_illegal", 32'(q_illegal_e), 32'd1);
    check("e_mul_busy", dut_e.busy, 32'd0);
    dbg_sel = 5'd20;
    #1 check("e_dbg_oor", dbg_data_e, 32'd0);
    instr = 32'h0000A103;
    tick();
    check("e_lw_r1", q_r1_e, 32'd5);
    check("e_lw_busy", dut_e.busy, 32'h4);
    instr = 32'h002101B3;
    #1 check("e_ld_use_stall", 32'(ready_e), 32'd0);
    wb(5'd2, 32'h55);
    #1 check("e_no_bypass_stall", 32'(ready_e), 32'd0);
    tick();
    write_reg = 1'b0;
    #1 check("e_late_ready", 32'(ready_e), 32'd1);
    tick();
    valid_e = 1'b0;
    check("e_add_r1", q_r1_e, 32'h55);
    check("e_add_r2s", q_r2s_e, 32'h55);
    check("e_add_busy", dut_e.busy, 32'h8);

    // Reset mid-stream with busy[7] set and a held bundle
    wb(5'd7, 32'h77);
    tick();
    write_reg = 1'b0; dbg_sel = 5'd7;
    #1 check("x7_dbg", dbg_data, 32'h77);
    q_ready = 1'b0; valid = 1'b1; instr = 32'h00100393;
    tick();
    valid = 1'b0;
    check("pre_rst_valid", 32'(q_valid), 32'd1);
    check("pre_rst_busy", dut.busy, 32'h92);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(q_valid), 32'd0);
    check("mid_rst_busy", dut.busy, 32'd0);
    check("mid_rst_x7", dbg_data, 32'd0);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
